// File: rtl/pll_rst_seq.sv
// PLL reset / lock-filter / staggered channel-release sequencer.
// Drives the PLL reset pulse, qualifies lock, then frees channel resets one slot at a time.
//
// state     | meaning
// ----------+------------------------------------------------------------
// PLL_RST   | pll_reset high for PLL_RST_CYC cycles
// WAIT_LOCK | PLL free-running, waiting for synchronized lock
// FILTER    | counting consecutive lock cycles, timeout still running
// RELEASE   | locked; channel resets freed one every REL_GAP cycles
// RUN       | all slots done, channel resets follow ch_mask
// FAIL      | retries exhausted; PLL and channels held in reset
module pll_rst_seq #(
    parameter int NUM_CH       = 2,
    parameter int PLL_RST_CYC  = 32,
    parameter int LOCK_FILT    = 16,
    parameter int REL_GAP      = 8,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int MAX_RETRY    = 3
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              lock_in,
    input  logic              soft_rst,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              pll_reset,
    output logic [NUM_CH-1:0] ch_rst,
    output logic              locked,
    output logic              fail,
    output logic [3:0]        retry_cnt,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_FILTER    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    localparam int PW = $clog2(PLL_RST_CYC + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int FW = $clog2(LOCK_FILT + 1);
    localparam int GW = $clog2(REL_GAP + 1);
    localparam int CW = $clog2(NUM_CH + 1);

    localparam logic [PW-1:0] P_END    = PW'(PLL_RST_CYC);
    localparam logic [TW-1:0] T_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [FW-1:0] F_LAST   = FW'(LOCK_FILT - 1);
    localparam logic [GW-1:0] G_LAST   = GW'(REL_GAP - 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);
    localparam logic [3:0]    R_MAX    = 4'(MAX_RETRY);

    state_t            st;
    logic              lock_m;
    logic              lock_s;
    logic [PW-1:0]     pcnt;
    logic [TW-1:0]     tcnt;
    logic [FW-1:0]     fcnt;
    logic [GW-1:0]     gcnt;
    logic [CW-1:0]     rel_idx;
    logic [3:0]        retry_next;
    logic              timeout;

    // Channels with index >= first are still waiting for their release slot.
    function automatic logic [NUM_CH-1:0] held_from(input logic [CW-1:0] first);
        logic [NUM_CH-1:0] h;
        h = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            h[k] = (k >= int'(first));
        end
        return h;
    endfunction

    assign state      = st;
    assign timeout    = (tcnt == T_LAST);
    assign retry_next = (retry_cnt >= R_MAX) ? R_MAX : retry_cnt + 4'd1;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= lock_in;
            lock_s <= lock_m;
        end
    end

    // Entry into PLL_RST from a running state loads pcnt=1: the entry edge is the
    // first pulse cycle. After reset pcnt=0, so the first clkin edge is the first.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            st        <= S_PLL_RST;
            pll_reset <= 1'b1;
            ch_rst    <= '1;
            locked    <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= 4'd0;
            pcnt      <= '0;
            tcnt      <= '0;
            fcnt      <= '0;
            gcnt      <= '0;
            rel_idx   <= '0;
        end else if (soft_rst) begin
            st        <= S_PLL_RST;
            pll_reset <= 1'b1;
            ch_rst    <= '1;
            locked    <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= 4'd0;
            pcnt      <= PW'(1);
            tcnt      <= '0;
            fcnt      <= '0;
            gcnt      <= '0;
            rel_idx   <= '0;
        end else begin
            case (st)
                S_PLL_RST: begin
                    ch_rst <= '1;
                    if (pcnt == P_END) begin
                        st        <= S_WAIT_LOCK;
                        pll_reset <= 1'b0;
                        pcnt      <= '0;
                        tcnt      <= '0;
                        fcnt      <= '0;
                    end else begin
                        pll_reset <= 1'b1;
                        pcnt      <= pcnt + PW'(1);
                    end
                end

                S_WAIT_LOCK, S_FILTER: begin
                    if (st == S_FILTER && lock_s && fcnt == F_LAST) begin
                        locked  <= 1'b1;
                        ch_rst  <= ch_mask | held_from(CW'(1));
                        tcnt    <= '0;
                        fcnt    <= '0;
                        gcnt    <= '0;
                        rel_idx <= CW'(1);
                        st      <= (NUM_CH == 1) ? S_RUN : S_RELEASE;
                    end else if (timeout) begin
                        retry_cnt <= retry_next;
                        pll_reset <= 1'b1;
                        tcnt      <= '0;
                        fcnt      <= '0;
                        if (retry_next == R_MAX) begin
                            st   <= S_FAIL;
                            fail <= 1'b1;
                        end else begin
                            st   <= S_PLL_RST;
                            pcnt <= PW'(1);
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                        if (!lock_s) begin
                            st   <= S_WAIT_LOCK;
                            fcnt <= '0;
                        end else if (st == S_WAIT_LOCK) begin
                            st   <= S_FILTER;
                            fcnt <= '0;
                        end else begin
                            fcnt <= fcnt + FW'(1);
                        end
                    end
                end

                S_RELEASE, S_RUN: begin
                    if (!lock_s) begin
                        st        <= S_PLL_RST;
                        pll_reset <= 1'b1;
                        pcnt      <= PW'(1);
                        ch_rst    <= '1;
                        locked    <= 1'b0;
                        gcnt      <= '0;
                        rel_idx   <= '0;
                    end else if (st == S_RUN) begin
                        ch_rst <= ch_mask;
                    end else if (gcnt == G_LAST) begin
                        gcnt    <= '0;
                        rel_idx <= rel_idx + CW'(1);
                        ch_rst  <= ch_mask | held_from(rel_idx + CW'(1));
                        if (rel_idx == LAST_CH) begin
                            st <= S_RUN;
                        end
                    end else begin
                        gcnt   <= gcnt + GW'(1);
                        ch_rst <= ch_mask | held_from(rel_idx);
                    end
                end

                S_FAIL: begin
                    pll_reset <= 1'b1;
                    ch_rst    <= '1;
                    fail      <= 1'b1;
                end

                default: begin
                    st        <= S_PLL_RST;
                    pll_reset <= 1'b1;
                    pcnt      <= PW'(1);
                    ch_rst    <= '1;
                    locked    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed edge-exact checks followed by randomized lock/mask/restart traffic,
// compared every cycle against a phase/edge-arithmetic model of the sequencer.
module tb_pll_rst_seq;

    localparam int NUM_CH       = 2;
    localparam int PLL_RST_CYC  = 32;
    localparam int LOCK_FILT    = 16;
    localparam int REL_GAP      = 8;
    localparam int LOCK_TIMEOUT = 1000;
    localparam int MAX_RETRY    = 3;

    localparam int PH_PLL  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_LOCK = 2;
    localparam int PH_DEAD = 3;

    logic              clkin = 1'b0;
    logic              reset = 1'b1;
    logic              lock_in = 1'b0;
    logic              soft_rst = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic              pll_reset;
    logic [NUM_CH-1:0] ch_rst;
    logic              locked;
    logic              fail;
    logic [3:0]        retry_cnt;
    logic [2:0]        state;

    pll_rst_seq #(
        .NUM_CH(NUM_CH), .PLL_RST_CYC(PLL_RST_CYC), .LOCK_FILT(LOCK_FILT),
        .REL_GAP(REL_GAP), .LOCK_TIMEOUT(LOCK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clkin(clkin), .reset(reset), .lock_in(lock_in), .soft_rst(soft_rst),
        .ch_mask(ch_mask), .pll_reset(pll_reset), .ch_rst(ch_rst), .locked(locked),
        .fail(fail), .retry_cnt(retry_cnt), .state(state)
    );

    always #5 clkin = ~clkin;

    int n_cmp = 0;
    int n_bad = 0;
    int cur = 0;
    bit done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic summary();
        if (!done) begin
            done = 1'b1;
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        end
    endtask

    // Model: phases are tracked by the edge number at which they began; outputs
    // follow from edge-count differences against the sequencing rules.
    int n = 0;
    int ph = PH_PLL;
    int ph_start = 0;
    int wait_start = 0;
    int lock_edge = 0;
    int streak = 0;
    int retries = 0;
    logic [1:0] hist = '0;
    logic ls;
    bit m_valid = 1'b0;
    logic              e_pll, e_lk, e_fl;
    logic [NUM_CH-1:0] e_ch;
    logic [3:0]        e_rt;
    logic [2:0]        e_st;

    always @(posedge clkin) begin
        n++;
        if (reset) begin
            ph       = PH_PLL;
            ph_start = n + 1;
            retries  = 0;
            hist     = '0;
            m_valid  = 1'b0;
        end else begin
            ls   = hist[1];
            hist = {hist[0], lock_in};
            if (soft_rst) begin
                ph       = PH_PLL;
                ph_start = n;
                retries  = 0;
            end else begin
                case (ph)
                    PH_PLL: if (n - ph_start == PLL_RST_CYC) begin
                        ph         = PH_WAIT;
                        wait_start = n;
                        streak     = 0;
                    end
                    PH_WAIT: begin
                        streak = ls ? streak + 1 : 0;
                        if (streak == LOCK_FILT + 1) begin
                            ph        = PH_LOCK;
                            lock_edge = n;
                        end else if (n - wait_start == LOCK_TIMEOUT) begin
                            retries++;
                            if (retries == MAX_RETRY) ph = PH_DEAD;
                            else begin
                                ph       = PH_PLL;
                                ph_start = n;
                            end
                        end
                    end
                    PH_LOCK: if (!ls) begin
                        ph       = PH_PLL;
                        ph_start = n;
                    end
                    default: ;
                endcase
            end
            e_pll = (ph == PH_PLL) || (ph == PH_DEAD);
            e_lk  = (ph == PH_LOCK);
            e_fl  = (ph == PH_DEAD);
            e_rt  = 4'(retries);
            e_ch  = '1;
            case (ph)
                PH_PLL:  e_st = 3'd0;
                PH_WAIT: e_st = (streak > 0) ? 3'd2 : 3'd1;
                PH_LOCK: begin
                    e_st = (n >= lock_edge + (NUM_CH - 1) * REL_GAP) ? 3'd4 : 3'd3;
                    for (int k = 0; k < NUM_CH; k++)
                        e_ch[k] = (n >= lock_edge + k * REL_GAP) ? ch_mask[k] : 1'b1;
                end
                default: e_st = 3'd5;
            endcase
            m_valid = 1'b1;
        end
    end

    always @(negedge clkin) begin
        if (m_valid && !reset) begin
            n_cmp++;
            if ({pll_reset, ch_rst, locked, fail, retry_cnt, state} !==
                {e_pll, e_ch, e_lk, e_fl, e_rt, e_st}) begin
                n_bad++;
                $display("FAIL cycle t=%0t: got pll=%b ch=%b lk=%b fl=%b rt=%0d st=%0d, expected pll=%b ch=%b lk=%b fl=%b rt=%0d st=%0d",
                         $time, pll_reset, ch_rst, locked, fail, retry_cnt, state,
                         e_pll, e_ch, e_lk, e_fl, e_rt, e_st);
            end
            n_cmp++;
            if (!locked && ch_rst !== '1) begin
                n_bad++;
                $display("FAIL unlocked_release t=%0t: got ch=%b with locked=0, expected all ones", $time, ch_rst);
            end
        end
    end

    task automatic tick();
        @(posedge clkin);
        #1;
        cur++;
    endtask

    task automatic run_to(input int e);
        while (cur < e) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll"},   int'(pll_reset), 1);
        chk({tag, "_ch"},    int'(ch_rst), 3);
        chk({tag, "_lock"},  int'(locked), 0);
        chk({tag, "_fail"},  int'(fail), 0);
        chk({tag, "_retry"}, int'(retry_cnt), 0);
        chk({tag, "_state"}, int'(state), 0);
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish within time limit");
        summary();
        $finish;
    end

    initial begin
        int r, d, spent;
        reset = 1'b1;
        repeat (3) tick();
        chk_reset_vals("por");
        reset = 1'b0;
        cur = -1;

        run_to(31);  chk("pulse_end_pll", int'(pll_reset), 1); chk("pulse_end_st", int'(state), 0);
        run_to(32);  chk("wait_pll", int'(pll_reset), 0);      chk("wait_st", int'(state), 1);
        run_to(40);  lock_in = 1'b1;
        run_to(58);  chk("pre_lock", int'(locked), 0);         chk("pre_lock_st", int'(state), 2);
        run_to(59);  chk("lock", int'(locked), 1);             chk("lock_ch", int'(ch_rst), 2);
                     chk("lock_st", int'(state), 3);
        run_to(66);  chk("slot1_pre", int'(ch_rst), 2);
        run_to(67);  chk("slot1", int'(ch_rst), 0);            chk("run_st", int'(state), 4);
        run_to(70);  lock_in = 1'b0;
        run_to(72);  chk("loss_pre", int'(locked), 1);
        run_to(73);  chk("loss_ch", int'(ch_rst), 3);          chk("loss_lock", int'(locked), 0);
                     chk("loss_pll", int'(pll_reset), 1);      chk("loss_retry", int'(retry_cnt), 0);
                     chk("loss_st", int'(state), 0);
        run_to(105); chk("rewait_st", int'(state), 1);
        run_to(110); lock_in = 1'b1;
        run_to(120); lock_in = 1'b0;
        run_to(122); lock_in = 1'b1;
        run_to(123); chk("glitch_st", int'(state), 1);
        run_to(140); chk("glitch_pre", int'(locked), 0);       chk("glitch_pre_st", int'(state), 2);
        run_to(141); chk("glitch_lock", int'(locked), 1);      chk("glitch_retry", int'(retry_cnt), 0);
        run_to(149); chk("run2_st", int'(state), 4);
        run_to(150); soft_rst = 1'b1;
        run_to(151); soft_rst = 1'b0;
        chk("soft_st", int'(state), 0);  chk("soft_pll", int'(pll_reset), 1);
        chk("soft_ch", int'(ch_rst), 3); chk("soft_lock", int'(locked), 0);
        run_to(195); ch_mask = 2'b10;
        run_to(200); chk("mask_lock", int'(locked), 1);        chk("mask_ch0", int'(ch_rst), 2);
        run_to(208); chk("mask_hold", int'(ch_rst), 2);        chk("mask_run", int'(state), 4);
        run_to(210); chk("mask_pre", int'(ch_rst), 2);         ch_mask = 2'b00;
        run_to(211); chk("mask_clear", int'(ch_rst), 0);
        run_to(215); soft_rst = 1'b1;
        run_to(216); soft_rst = 1'b0;
        run_to(265); chk("rel2_lock", int'(locked), 1);        chk("rel2_st", int'(state), 3);
        run_to(268); chk("rel2_ch", int'(ch_rst), 2);
        #1 reset = 1'b1; lock_in = 1'b0;
        #1 chk_reset_vals("async");
        repeat (2) tick();
        reset = 1'b0;
        cur = -1;

        run_to(1031); chk("to1_pre", int'(retry_cnt), 0);      chk("to1_pre_st", int'(state), 1);
        run_to(1032); chk("to1", int'(retry_cnt), 1);          chk("to1_st", int'(state), 0);
                      chk("to1_pll", int'(pll_reset), 1);
        run_to(1064); chk("to1_wait", int'(state), 1);
        run_to(2063); chk("to2_pre", int'(retry_cnt), 1);
        run_to(2064); chk("to2", int'(retry_cnt), 2);          chk("to2_st", int'(state), 0);
        run_to(3095); chk("to3_pre", int'(state), 1);
        run_to(3096); chk("to3_fail", int'(fail), 1);          chk("to3_st", int'(state), 5);
                      chk("to3_pll", int'(pll_reset), 1);      chk("to3_retry", int'(retry_cnt), 3);
                      chk("to3_ch", int'(ch_rst), 3);
        run_to(3110); chk("fail_hold", int'(state), 5);        chk("fail_pll", int'(pll_reset), 1);
        soft_rst = 1'b1;
        run_to(3111); soft_rst = 1'b0;
        chk_reset_vals("fail_soft");
        run_to(3143); chk("restart_st", int'(state), 1);

        spent = 0;
        while (spent < 24000) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                soft_rst = 1'b1; tick(); soft_rst = 1'b0; spent++;
            end else if (r < 5) begin
                reset = 1'b1; tick(); reset = 1'b0; spent++;
            end else if (r < 15) begin
                ch_mask = NUM_CH'($urandom_range(0, 3));
                tick(); spent++;
            end else begin
                lock_in = ~lock_in;
                r = int'($urandom_range(0, 9));
                if (r < 4)      d = int'($urandom_range(1, 4));
                else if (r < 7) d = int'($urandom_range(10, 40));
                else            d = int'($urandom_range(50, 1300));
                repeat (d) tick();
                spent += d;
            end
        end

        summary();
        $finish;
    end

endmodule
